// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   function automatic int unsigned clks_per_bit(input int unsigned f_clk, input int unsigned baud);
      return f_clk / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with registered full/empty/ready flags and a look-ahead count.
module uart_tx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
)(
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rdata_c,
   output logic                       full,
   output logic                       empty,
   output logic                       ready,
   output logic [$clog2(DEPTH):0]     count_nxt_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             wr;
   logic             rd;

   assign wr      = push && !full;
   assign rd      = pop && !empty;
   assign rdata_c = mem[rd_ptr_q];

   // occupancy after this edge; simultaneous push and pop cancel
   always_comb begin
      count_nxt_c = count_q;
      case ({wr, rd})
         2'b10:   count_nxt_c = count_q + CNT_W'(1);
         2'b01:   count_nxt_c = count_q - CNT_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (wr) begin
         mem[wr_ptr_q] <= wdata;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         ready    <= 1'b0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_nxt_c;
         full    <= (count_nxt_c == CNT_W'(DEPTH));
         empty   <= (count_nxt_c == '0);
         ready   <= (count_nxt_c != CNT_W'(DEPTH));
      end
   end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO and zero-gap back-to-back frames.
// Optional parity is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int unsigned F_CLK        = 12_000_000,
   parameter int unsigned UART_BAUD    = 9600,
   parameter int unsigned CLKS_PER_BIT = clks_per_bit(F_CLK, UART_BAUD),
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned STOP_BITS    = 2,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned FIFO_DEPTH   = 4
)(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 TX_VALID,
   input  logic [DATA_BITS-1:0] TX_WORD,
   output logic                 TX_READY,
   output logic                 TX_DATA,
   output logic                 BUSY,
   output logic                 DONE
);

   localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

   localparam logic [2:0] S_IDLE   = ST_IDLE;
   localparam logic [2:0] S_START  = ST_START;
   localparam logic [2:0] S_DATA   = ST_DATA;
   localparam logic [2:0] S_STOP   = ST_STOP;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = ST_PARITY;
   localparam bit         PAR_ON   = (PARITY != PAR_NONE);
`endif

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
       (STOP_BITS != 1 && STOP_BITS != 2) || PARITY > 2 ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("uart_tx_param: illegal parameter combination");
   end

   logic [2:0]           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   logic                 bit_end;
   logic                 load;
   logic                 pop;
   logic                 push;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_ready;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic [FCNT_W-1:0]    fifo_count_nxt;

   assign push    = TX_VALID && fifo_ready && !fifo_full;
   assign bit_end = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK         (CLK),
      .RST         (RST),
      .push        (push),
      .wdata       (TX_WORD),
      .pop         (pop),
      .rdata_c     (fifo_rdata),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .ready       (fifo_ready),
      .count_nxt_c (fifo_count_nxt)
   );

   // next-state, shifter and line-level logic
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      done_d  = 1'b0;
      load    = 1'b0;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      case (state_q)
         S_IDLE: begin
            tx_d  = 1'b1;
            cnt_d = '0;
            load  = !fifo_empty;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               idx_d   = '0;
               tx_d    = sh_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                  idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  if (PAR_ON) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
`else
                  state_d = S_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
                  sh_d  = sh_q >> 1;
                  tx_d  = sh_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               idx_d   = '0;
               tx_d    = 1'b1;
            end
         end
`endif
         S_STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (idx_q == IDX_W'(STOP_BITS - 1)) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  idx_d   = '0;
                  load    = !fifo_empty;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
            tx_d    = 1'b1;
         end
      endcase

      // a waiting word starts its start bit on this edge (also from STOP: zero gap)
      if (load) begin
         pop     = 1'b1;
         state_d = S_START;
         sh_d    = fifo_rdata;
         tx_d    = 1'b0;
         cnt_d   = '0;
         idx_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
`endif
      end

      busy_d = (state_d != S_IDLE) || (fifo_count_nxt != '0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign TX_READY = fifo_ready;
   assign TX_DATA  = tx_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: two instances (8-bit/2-stop and 5-bit/1-stop) checked
// cycle by cycle against an expected line waveform built from the frame format.
module tb_uart_tx_param;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST;
   logic [1:0] valid;
   logic [1:0] ready;
   logic [1:0] txd;
   logic [1:0] busy;
   logic [1:0] done;
   logic [7:0] word_a;
   logic [4:0] word_b;

   int n_checks = 0;
   int n_errors = 0;
   bit exp_q[$];
   int batch[$];

   always #5 CLK = ~CLK;

   uart_tx_param #(
      .CLKS_PER_BIT (CPB), .DATA_BITS (8), .STOP_BITS (2), .PARITY (2), .FIFO_DEPTH (4)
   ) u_dut_a (
      .CLK (CLK), .RST (RST), .TX_VALID (valid[0]), .TX_WORD (word_a),
      .TX_READY (ready[0]), .TX_DATA (txd[0]), .BUSY (busy[0]), .DONE (done[0])
   );

   uart_tx_param #(
      .CLKS_PER_BIT (CPB), .DATA_BITS (5), .STOP_BITS (1), .PARITY (1), .FIFO_DEPTH (4)
   ) u_dut_b (
      .CLK (CLK), .RST (RST), .TX_VALID (valid[1]), .TX_WORD (word_b),
      .TX_READY (ready[1]), .TX_DATA (txd[1]), .BUSY (busy[1]), .DONE (done[1])
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic int dbits(input int s);
      return (s != 0) ? 5 : 8;
   endfunction

   function automatic int sbits(input int s);
      return (s != 0) ? 1 : 2;
   endfunction

   // instance A is even parity, instance B odd parity (only when compiled in)
   function automatic int frame_len(input int s);
      return CPB * (1 + dbits(s) + (PAR_EN ? 1 : 0) + sbits(s));
   endfunction

   task automatic drive(input int s, input bit v, input int w);
      valid[s] = v;
      if (s == 0) word_a = 8'(w);
      else        word_b = 5'(w);
   endtask

   // expected per-cycle line level for one frame
   task automatic add_frame(input int s, input int w);
      int ones;
      bit p;
      repeat (CPB) exp_q.push_back(1'b0);
      for (int b = 0; b < dbits(s); b++)
         repeat (CPB) exp_q.push_back(w[b]);
      if (PAR_EN) begin
         ones = $countones(w);
         p = (s == 0) ? (ones % 2 == 1) : (ones % 2 == 0);
         repeat (CPB) exp_q.push_back(p);
      end
      repeat (CPB * sbits(s)) exp_q.push_back(1'b1);
   endtask

   // push every word of batch on consecutive edges from idle, then follow the line
   task automatic run_batch(input int s);
      int k, len, total, pushes, pops;
      bit exp_tx, exp_done;
      string tg;
      k = batch.size();
      len = frame_len(s);
      total = k * len;
      exp_q.delete();
      foreach (batch[i]) add_frame(s, batch[i]);
      for (int t = 0; t <= total + 2; t++) begin
         if (t < k) drive(s, 1'b1, batch[t]);
         else       drive(s, 1'b0, int'($urandom));
         tick();
         pushes = (t + 1 < k) ? t + 1 : k;
         pops = 0;
         for (int i = 0; i < k; i++)
            if (i * len + 1 <= t) pops++;
         exp_tx   = (t >= 1 && t - 1 < total) ? exp_q[t - 1] : 1'b1;
         exp_done = (t >= len + 1) && ((t - 1) % len == 0) && ((t - 1) / len <= k);
         tg = $sformatf("dut%0d t%0d", s, t);
         chk({"tx ", tg},    txd[s],   exp_tx);
         chk({"done ", tg},  done[s],  exp_done);
         chk({"busy ", tg},  busy[s],  t <= total);
         chk({"ready ", tg}, ready[s], (pushes - pops) != 4);
      end
      drive(s, 1'b0, 0);
   endtask

   task automatic idle_check(input int n);
      for (int c = 0; c < n; c++) begin
         tick();
         for (int s = 0; s < 2; s++) begin
            chk($sformatf("idle tx dut%0d", s),    txd[s],   1'b1);
            chk($sformatf("idle busy dut%0d", s),  busy[s],  1'b0);
            chk($sformatf("idle done dut%0d", s),  done[s],  1'b0);
            chk($sformatf("idle ready dut%0d", s), ready[s], 1'b1);
         end
      end
   endtask

   initial begin
      int s;
      int k;
      RST = 1'b1;
      valid = '0;
      word_a = '0;
      word_b = '0;
      repeat (3) tick();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("rst tx dut%0d", i),    txd[i],   1'b1);
         chk($sformatf("rst ready dut%0d", i), ready[i], 1'b0);
         chk($sformatf("rst busy dut%0d", i),  busy[i],  1'b0);
         chk($sformatf("rst done dut%0d", i),  done[i],  1'b0);
      end
      RST = 1'b0;
      idle_check(2);

      batch = '{32'hA5};
      run_batch(0);
      batch = '{32'h01, 32'h02, 32'h03};
      run_batch(0);
      batch = '{32'h1F};
      run_batch(1);
      batch = '{32'h07, 32'h00, 32'hFF, 32'h3C, 32'h80};
      run_batch(0);
      batch = '{32'h00, 32'h15, 32'h0A, 32'h1F, 32'h01};
      run_batch(1);
      idle_check(1);

      for (int it = 0; it < 8; it++) begin
         s = int'($urandom_range(0, 1));
         k = int'($urandom_range(1, 5));
         batch.delete();
         for (int i = 0; i < k; i++)
            batch.push_back(int'($urandom_range(0, (1 << dbits(s)) - 1)));
         run_batch(s);
         idle_check(int'($urandom_range(0, 3)));
      end

      // abort a frame mid-data with a second word still queued
      drive(0, 1'b1, 32'hC3);
      tick();
      drive(0, 1'b1, 32'h3C);
      tick();
      drive(0, 1'b0, 0);
      repeat (10) tick();
      chk("pre-rst busy", busy[0], 1'b1);
      RST = 1'b1;
      drive(0, 1'b1, 32'hFF);
      tick();
      chk("abort tx", txd[0], 1'b1);
      chk("abort busy", busy[0], 1'b0);
      chk("abort done", done[0], 1'b0);
      chk("abort ready", ready[0], 1'b0);
      drive(0, 1'b0, 0);
      RST = 1'b0;
      idle_check(60);
      batch = '{32'h55};
      run_batch(0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter, successor to the fixed 8-bit transmitter. It adds configurable data width, stop-bit count and optional parity, plus a small input FIFO behind a ready/valid handshake. Back-to-back frames go out with no idle gap. It sits between any byte producer (command logic, loopback/mirror path) and the board's serial TX pin.

## Interface
- F_CLK, 12_000_000, system clock frequency in Hz
- UART_BAUD, 9600, line rate
- CLKS_PER_BIT, F_CLK/UART_BAUD, clocks per bit; integer ≥ 2
- DATA_BITS, 8, payload width; legal 5..9
- STOP_BITS, 2, legal 1 or 2
- PARITY, 0, 0 none / 1 odd / 2 even; ignored unless UART_TX_PARITY_EN is defined
- FIFO_DEPTH, 4, entries; power of 2, ≥ 2

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- TX_VALID  in  1  producer offers TX_WORD
- TX_WORD  in  DATA_BITS  word to send, LSB first
- TX_READY  out  1  FIFO can accept; a transfer occurs on an edge with TX_VALID && TX_READY
- TX_DATA  out  1  serial line, idles high
- BUSY  out  1  frame in progress or FIFO non-empty
- DONE  out  1  one-cycle pulse at the end of each frame's last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_DATA=1. If the FIFO is non-empty: pop into the shift register, set TX_DATA<=0, go to START.
- START: hold 0 for CLKS_PER_BIT, then go to DATA.
- DATA: send bit[idx], idx 0..DATA_BITS-1, each held CLKS_PER_BIT. After the last bit, go to PARITY if parity is active, else STOP.
- PARITY: odd parity makes the total count of ones (data+parity) odd; even parity makes it even. Computed on the latched word. Held CLKS_PER_BIT.
- STOP: TX_DATA=1 for STOP_BITS×CLKS_PER_BIT.
  - At the final cycle, pulse DONE.
  - If the FIFO is non-empty, pop and enter START directly: TX_DATA goes 0 on the same edge, giving zero gap.
  - Otherwise go to IDLE.
- Illegal state encoding: go to IDLE, TX_DATA=1.
- FIFO:
  - A push and pop on the same edge leaves count unchanged.
  - A push when full cannot occur because TX_READY=0.
  - A pop when empty never occurs.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is $clog2(FIFO_DEPTH)+1.
- Bit-clock counter width is $clog2(CLKS_PER_BIT). It resets to 0 at every bit boundary; stop bits are counted by the bit index, not by a wider counter.
- TX_WORD is captured only on an accepted transfer. The value between transfers is don't-care.

## Timing
- Reset values: TX_DATA=1, TX_READY=0, BUSY=0, DONE=0, state IDLE, FIFO empty.
- After reset: TX_READY=1 on the first edge after RST deasserts.
- RST during a frame: aborts the frame. TX_DATA=1 on the next edge, FIFO flushed, no DONE pulse.
- TX_VALID is ignored while RST is high.
- Latency: a word accepted at edge N with the FIFO empty and the block in IDLE drives TX_DATA low from edge N+1.
- Frame length: CLKS_PER_BIT×(1+DATA_BITS+P+STOP_BITS) cycles, where P=1 if parity is active.
- TX_READY is registered and equals !full after each edge.

## Configuration
- UART_TX_PARITY_EN
  - Defined: PARITY selects none/odd/even, and the PARITY state and its logic are compiled in.
  - Undefined: no parity logic is synthesised, frames are always parity-less, and PARITY is ignored.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP);
  - parity-mode constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2;
  - the clks_per_bit helper function.
- One sub-module, uart_tx_fifo: synchronous FIFO parametrised by width and depth, exposing full, empty, push and pop.
- Shifter and FSM live in uart_tx_param.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless noted.
- 8N2, send 0xA5 → TX_DATA: 0 for 4 cycles; then 1,0,1,0,0,1,0,1 at 4 cycles each; then 1 for 8 cycles. DONE pulses once, 44 cycles after the start bit begins.
- UART_TX_PARITY_EN, 8E1, send 0x07 → parity bit 1. 8O1, send 0x07 → parity bit 0. Frame length 44 cycles.
- FIFO_DEPTH=4, TX_VALID held high from idle → 5 words accepted on 5 consecutive edges, then TX_READY=0. TX_READY then returns to 1 for one acceptance per frame.
- Three queued words 0x01, 0x02, 0x03 → the stop bit of each frame is followed immediately by the next start bit with no idle gap. Exactly 3 DONE pulses, then BUSY=0.
- RST asserted mid-DATA → TX_DATA=1 on the next edge, no DONE, BUSY=0. After release, TX_READY=1 and a fresh 0x55 transmits correctly.
- DATA_BITS=5, STOP_BITS=1, send 0x1F → frame 28 cycles: start, 1,1,1,1,1, stop.
